// File: rtl/elevator_pkg.sv
// Shared floor, direction and bit-index definitions for the elevator request path.
// Latency: none (types, constants and pure helper functions only).
// Backpressure: not applicable.
package elevator_pkg;

  // Floor codes; NONE means no target is currently selected.
  typedef enum logic [1:0] {
    FLOOR_NONE = 2'd0,
    FLOOR_1    = 2'd1,
    FLOOR_2    = 2'd2,
    FLOOR_3    = 2'd3
  } floor_t;

  // Last travel direction, used to break equal-distance ties.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam int NUM_FLOORS = 3;

  // Bit positions in the call vector sent to the controller.
  localparam int CALL_F1   = 0;
  localparam int CALL_F3   = 2;
  localparam int CALL_HOLD = 3;

  // Bit positions in the status vector returned by the controller.
  localparam int ST_F1   = 0;
  localparam int ST_F3   = 2;
  localparam int ST_DOOR = 3;

  // One-hot call bits for a floor code; NONE maps to no call.
  function automatic logic [2:0] floor_onehot(input floor_t f);
    logic [2:0] oh;
    oh = 3'b000;
    case (f)
      FLOOR_1: oh = 3'b001;
      FLOOR_2: oh = 3'b010;
      FLOOR_3: oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // Floor code for a zero-based floor index (0..2).
  function automatic floor_t idx_to_floor(input logic [1:0] idx);
    floor_t f;
    case (idx)
      2'd0:    f = FLOOR_1;
      2'd1:    f = FLOOR_2;
      default: f = FLOOR_3;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/input_debounce.sv
// Synchronizes one asynchronous input and accepts a level only after it is stable.
// Latency: level changes DEBOUNCE_CYCLES+1 edges after the raw change is first sampled.
// Backpressure: none; free-running, one sample per clock.
module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchronizer, then count consecutive disagreeing samples and flip the level on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST_CNT) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hall_call_panel.sv
// Hall call front end: debounces buttons/obstruction, latches calls, selects one target, times door hold.
// Latency: pending sets DEBOUNCE_CYCLES+2 edges after a press, target one edge later; hold is combinational.
// Backpressure: none; calls stay latched until the controller status shows them served.
module hall_call_panel
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int DOOR_HOLD_CYCLES = 8,
  parameter int CNT_W            = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn_raw,
  input  logic       obstruct_raw,
  input  logic [3:0] car_status,
  output logic [3:0] call_out,
  output logic [2:0] pending
);

  // The first open cycle is covered by the door_rise term, so the counter only
  // carries the cycles that remain after it.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(DOOR_HOLD_CYCLES - 1);

  logic [2:0]       btn_lvl;
  logic [2:0]       btn_prev;
  logic [2:0]       btn_rise;
  logic [2:0]       serve;
  logic             obs_lvl;
  logic             door;
  logic             door_was_closed;
  logic             door_rise;
  logic [CNT_W-1:0] hold_cnt;
  logic             hold;
  logic             floor_valid;
  logic [1:0]       cur_idx;
  logic [1:0]       pick_idx;
  floor_t           target;
  floor_t           target_nxt;
  dir_t             dir;
  dir_t             dir_nxt;

  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_btn
    input_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_btn_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw[i]),
      .level(btn_lvl[i])
    );
  end

  input_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_obs_db (
    .clk  (clk),
    .rst  (rst),
    .raw  (obstruct_raw),
    .level(obs_lvl)
  );

  assign door      = car_status[ST_DOOR];
  assign btn_rise  = btn_lvl & ~btn_prev;
  assign serve     = car_status[ST_F3:ST_F1] & {3{door}};
  // door_was_closed resets low, so a door already open across reset is not a fresh opening.
  assign door_rise = door & door_was_closed;

  // Decode the current floor; anything other than exactly one floor bit is no floor.
  always_comb begin
    floor_valid = 1'b1;
    cur_idx     = 2'd0;
    case (car_status[ST_F3:ST_F1])
      3'b001:  cur_idx = 2'd0;
      3'b010:  cur_idx = 2'd1;
      3'b100:  cur_idx = 2'd2;
      default: floor_valid = 1'b0;
    endcase
  end

  // Nearest pending floor from the current one; the middle floor breaks ties by travel direction.
  always_comb begin
    pick_idx = 2'd0;
    case (cur_idx)
      2'd0: begin
        if (pending[0])      pick_idx = 2'd0;
        else if (pending[1]) pick_idx = 2'd1;
        else                 pick_idx = 2'd2;
      end
      2'd1: begin
        if (pending[1])                   pick_idx = 2'd1;
        else if (pending[0] & pending[2]) pick_idx = (dir == DIR_UP) ? 2'd2 : 2'd0;
        else if (pending[0])              pick_idx = 2'd0;
        else                              pick_idx = 2'd2;
      end
      default: begin
        if (pending[2])      pick_idx = 2'd2;
        else if (pending[1]) pick_idx = 2'd1;
        else                 pick_idx = 2'd0;
      end
    endcase
  end

  // Target/direction next state: select only when idle with the door shut, release once the call is served.
  always_comb begin
    target_nxt = target;
    dir_nxt    = dir;
    if (target == FLOOR_NONE) begin
      if ((pending != 3'b000) && !door && floor_valid) begin
        target_nxt = idx_to_floor(pick_idx);
        if (pick_idx > cur_idx) begin
          dir_nxt = DIR_UP;
        end else if (pick_idx < cur_idx) begin
          dir_nxt = DIR_DOWN;
        end
      end
    end else if ((floor_onehot(target) & pending) == 3'b000) begin
      target_nxt = FLOOR_NONE;
    end
  end

  // Target and direction state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      target <= FLOOR_NONE;
      dir    <= DIR_UP;
    end else begin
      target <= target_nxt;
      dir    <= dir_nxt;
    end
  end

  // Call lamps: set on a new debounced press, cleared when served; a serve beats a same-cycle press.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= 3'b000;
      btn_prev <= 3'b000;
    end else begin
      pending  <= (pending | btn_rise) & ~serve;
      btn_prev <= btn_lvl;
    end
  end

  // Door hold timer: reload on each opening, count down while open, clear while closed.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt        <= '0;
      door_was_closed <= 1'b0;
    end else begin
      door_was_closed <= ~door;
      if (door_rise) begin
        hold_cnt <= HOLD_LOAD;
      end else if (!door) begin
        hold_cnt <= '0;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

  assign hold = door & (door_rise | (hold_cnt != '0) | obs_lvl);

  assign call_out[CALL_HOLD]       = hold;
  assign call_out[CALL_F3:CALL_F1] = floor_onehot(target);

endmodule

// File: doc/hall_call_panel.md
# hall_call_panel

Request-side front end for the elevator controller: conditions the three floor call buttons and the door obstruction sensor, latches calls until served, and drives the controller's 4-bit call input (call floor 1, call floor 2, call floor 3, door hold). It also consumes the controller's 4-bit status output (at floor 1, at floor 2, at floor 3, door open) to clear served calls and to time the door-open hold. The controller has no door timer, so this block supplies it.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive synchronized samples required to accept a level change.
- DOOR_HOLD_CYCLES, 8: cycles the hold bit stays asserted after the door opens.
- CNT_W, 8: width of the debounce and hold counters. Both cycle parameters must be below 2^CNT_W.
- clk  in  1  system clock
- rst  in  1  reset, synchronous and active-high
- btn_raw  in  3  raw call buttons; bit 0 = floor 1, bit 2 = floor 3; asynchronous
- obstruct_raw  in  1  raw door obstruction sensor; asynchronous
- car_status  in  4  controller status; bit 0..2 = at floor 1..3, bit 3 = door open
- call_out  out  4  to the controller; bit 0..2 = one-hot selected target floor, bit 3 = door hold
- pending  out  3  latched call lamps, one per floor

## Operation
- Synchronizer: a 2-flop synchronizer on each of btn_raw[2:0] and obstruct_raw.
- Debounce, per input:
  - A counter increments while the synchronized value differs from the debounced level, and resets to 0 when they match.
  - The debounced level flips on the edge where the counter would reach DEBOUNCE_CYCLES.
- Press: a rising edge of a debounced button (debounced & ~previous debounced) sets pending[i].
- Serve:
  - pending[i] clears when car_status shows floor i with the door open.
  - If a set and a clear hit the same cycle, clear wins.
- Current floor: the one-hot bits car_status[2:0]. If they are not exactly one-hot, there is no valid floor and no new selection happens.
- Target register: values NONE, F1, F2, F3.
  - Selection happens only when target = NONE, pending != 0, car_status[3] = 0 and the floor is valid.
  - The nearest pending floor wins, and distance 0 is allowed.
  - If two floors are equally near, the winner continues the last travel direction.
  - The target holds until pending[target] clears, then returns to NONE on the following edge.
- Direction register: UP or DOWN. It updates when a target is selected above or below the current floor and is unchanged for distance 0.
- Hold timer:
  - Loads DOOR_HOLD_CYCLES on a rising edge of car_status[3].
  - Decrements while car_status[3] = 1 and the count is nonzero.
  - Forced to 0 while the door is closed.
- call_out[3] = car_status[3] & (timer != 0 | debounced obstruction). Hold is never asserted while the door is closed.
- call_out[2:0] = one-hot of the target; 000 when the target is NONE. At most one call bit is ever set, so the controller always sees the exact single-call patterns it decodes.

## Timing
- Reset value of every register: 0. Direction resets to UP and the target to NONE. Outputs after reset: call_out = 0000, pending = 000.
- Reset mid-operation clears pending, target, timer, counters and synchronizers on the next edge, with no residual hold.
- Press latency: with btn_raw first sampled high at edge k, pending sets at edge k+DEBOUNCE_CYCLES+2 and call_out shows the target at edge k+DEBOUNCE_CYCLES+3 (when selectable).
- A pulse shorter than DEBOUNCE_CYCLES synchronized cycles is ignored.
- Serve latency: pending clears on the first edge at which status shows the floor with the door open. The target returns to NONE one edge later.
- Hold: call_out[3] is high combinationally in the first door-open cycle, stays high for DOOR_HOLD_CYCLES cycles, then drops unless obstruction is debounced high.
- A door reopen (the door bit falls and rises again) reloads the timer.
- Holding a button does not re-trigger; only a new debounced rising edge sets pending.

## Structure
- Shared package elevator_pkg:
  - floor codes (NONE, F1, F2, F3)
  - call-vector and status-vector bit index constants
  - direction encoding
- Sub-module input_debounce (2-flop synchronizer plus counter plus debounced level, parameterized by DEBOUNCE_CYCLES and CNT_W), instantiated four times.
- Selection, direction, hold timer and pending latches live in hall_call_panel.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and DOOR_HOLD_CYCLES=8.
- Reset: assert rst for 2 cycles -> call_out = 0000, pending = 000. No change with idle inputs for 20 cycles.
- Single call: car_status = 1000, btn_raw[2] high 10 cycles from edge k -> pending = 001 at k+6, call_out = 0010 at k+7. Then car_status = 0011 -> pending = 000 that edge, call_out = 0000 the next edge.
- Glitch: btn_raw[1] high for 3 cycles -> pending stays 000, call_out stays 0000.
- Door hold: car_status 1000 -> 1001 -> call_out[3] = 1 for exactly 8 cycles, then 0.
  - With obstruct_raw held high -> call_out[3] stays 1.
  - With car_status door bit 0 -> call_out[3] = 0 regardless of obstruction.
- Tie-break: car at 0100 with last direction UP, pending floors 1 and 3 -> call_out = 0010. After floor 3 is served, with the car back at 0100 -> call_out = 1000.
- Reset mid-operation: pending = 101, hold timer at 5, door open -> one-cycle rst clears pending, target and hold on the next edge.
